watch_dp: RTL and testbench
===========================

Name: watch_dp

Overview:
- Watch datapath that consumes the single-cycle set pulses produced by the watch control FSM (sec/min/hour up).
- Divides the system clock down to a 10 ms tick.
- Keeps a running time-of-day in four cascaded counters: centiseconds, seconds, minutes, hours.
- Counter outputs feed the FND/UART display formatting stage downstream.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- TICK_HZ, 100, base tick rate in Hz. Tick divider DIV = CLK_FREQ/TICK_HZ, and must be an integer ≥ 2.
- INIT_HOUR, 12, hour value loaded at reset (0..23).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- i_secup  input  1  one-cycle pulse: advance seconds by one.
- i_minup  input  1  one-cycle pulse: advance minutes by one.
- i_hourup  input  1  one-cycle pulse: advance hours by one.
- o_msec  output  7  centiseconds, 0..99.
- o_sec  output  6  seconds, 0..59.
- o_min  output  6  minutes, 0..59.
- o_hour  output  5  hours, 0..23.
- o_tick  output  1  registered one-cycle pulse, high in the cycle after the divider wraps.

Behaviour:
- One clock: clk. Reset is synchronous and active-high: rst is sampled only on the rising edge of clk.
- Reset values:
  - divider count = 0, o_tick = 0.
  - o_msec = 0, o_sec = 0, o_min = 0, o_hour = INIT_HOUR.
- rst overrides all other inputs in the same cycle. Reset mid-count discards partial divider progress.
- Divider:
  - Counter runs 0..DIV-1 and wraps to 0.
  - Internal tick_int = 1 in the cycle count == DIV-1.
  - o_tick is tick_int registered (one cycle later).
  - Tick period is exactly DIV clocks.
- Natural cascade, all fields registered and updated on the same edge:
  - msec increments when tick_int = 1. Carry c0 = tick_int & (msec == 99).
  - sec increments on c0. Carry c1 = c0 & (sec == 59).
  - min increments on c1. Carry c2 = c1 & (min == 59).
  - hour increments on c2. Wraps 23 -> 0, no carry out.
- Manual set:
  - i_secup / i_minup / i_hourup each add 1 to their field, modulo 60/60/24.
  - Manual increments never generate a carry into the next field. Example: sec 59 + i_secup -> 0, min unchanged.
  - msec is not affected by set pulses.
- Simultaneous events, per field:
  - next = (cur + natural_inc + manual_inc) mod N, where each inc is 0 or 1.
  - Carry out depends only on natural_inc with cur == N-1.
  - Example: sec = 59, c0 = 1, i_secup = 1 -> sec = 1, c1 = 1.
  - Example: sec = 58, c0 = 1, i_secup = 1 -> sec = 0, c1 = 0.
- Multiple set inputs high in the same cycle are each applied to their own field independently.
- Set pulses held high for k cycles advance the field k times. Pulse qualification is the upstream FSM's job.
- Arithmetic uses field width + 1 bits before the modulo compare. No out-of-range value ever appears on the outputs.
- Latency:
  - Set pulse at edge n -> field updated after edge n (visible cycle n+1).
  - Tick-driven updates coincide with the edge where tick_int = 1.

Test Plan:
- Reset: rst = 1 for 3 cycles -> o_msec = 0, o_sec = 0, o_min = 0, o_hour = 12, o_tick = 0. Release -> first o_tick DIV+1 clocks after release, then every DIV clocks.
- Cascade rollover (CLK_FREQ = 1000, TICK_HZ = 100, DIV = 10): preload 23:59:59.99 via set pulses + ticks, apply one tick -> 00:00:00.00. Check all four fields change on the same edge.
- Manual wrap without carry: sec = 59, pulse i_secup -> sec = 0, min unchanged. min = 59, i_minup -> min = 0, hour unchanged. hour = 23, i_hourup -> hour = 0.
- Collision: msec = 99, sec = 59, min = 10; drive i_secup in the tick cycle -> sec = 1, min = 11, msec = 0.
- Simultaneous pulses: i_secup = i_minup = i_hourup = 1 for one cycle from 12:00:00 -> 13:01:01. Held for 3 cycles -> 16:04:04 (from 13:01:01).
- Reset mid-operation: assert rst when divider count = 7 and time = 05:30:20.45 -> next cycle all reset values. The following tick arrives a full DIV clocks later.

Source files
------------

// File: rtl/watch_dp.sv
// watch_dp: time-of-day datapath for the watch.
// 10 ms tick divider feeding cs/sec/min/hour counters plus set pulses.

module watch_dp #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned INIT_HOUR = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_secup,
  input  logic       i_minup,
  input  logic       i_hourup,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_tick
);

  localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  function automatic logic [6:0] inc100(
    input logic [6:0] cur,
    input logic       nat
  );
    logic [7:0] s;
    s = {1'b0, cur} + {7'd0, nat};
    if (s >= 8'd100) s = s - 8'd100;
    return s[6:0];
  endfunction

  // Natural and manual steps add together; the wrap covers both at once.
  function automatic logic [5:0] inc60(
    input logic [5:0] cur,
    input logic       nat,
    input logic       man
  );
    logic [6:0] s;
    s = {1'b0, cur} + {6'd0, nat} + {6'd0, man};
    if (s >= 7'd60) s = s - 7'd60;
    return s[5:0];
  endfunction

  function automatic logic [4:0] inc24(
    input logic [4:0] cur,
    input logic       nat,
    input logic       man
  );
    logic [5:0] s;
    s = {1'b0, cur} + {5'd0, nat} + {5'd0, man};
    if (s >= 6'd24) s = s - 6'd24;
    return s[4:0];
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic [6:0]    msec_q, msec_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic          tick_int;
  logic          c0, c1, c2;

  always_comb begin
    tick_int = (cnt_q == DIV_LAST);
    cnt_d    = tick_int ? '0 : cnt_q + 1'b1;
    tick_d   = tick_int;
    c0       = tick_int & (msec_q == 7'd99);
    c1       = c0 & (sec_q == 6'd59);
    c2       = c1 & (min_q == 6'd59);
    msec_d   = inc100(msec_q, tick_int);
    sec_d    = inc60(sec_q, c0, i_secup);
    min_d    = inc60(min_q, c1, i_minup);
    hour_d   = inc24(hour_q, c2, i_hourup);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      msec_q <= 7'd0;
      sec_q  <= 6'd0;
      min_q  <= 6'd0;
      hour_q <= 5'(INIT_HOUR);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      msec_q <= msec_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
    end
  end

  assign o_msec = msec_q;
  assign o_sec  = sec_q;
  assign o_min  = min_q;
  assign o_hour = hour_q;
  assign o_tick = tick_q;

endmodule

// File: tb/tb_watch_dp.sv
// tb_watch_dp: directed + random checks of watch_dp (DIV = 10)
// against a total-centisecond reference model.

module tb_watch_dp;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_secup = 1'b0;
  logic       i_minup = 1'b0;
  logic       i_hourup = 1'b0;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_tick;

  int errors = 0;
  int checks = 0;

  int m_ms, m_s, m_m, m_h, m_n;
  bit m_tk;

  watch_dp #(
    .CLK_FREQ (1000),
    .TICK_HZ  (100),
    .INIT_HOUR(12)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_secup (i_secup),
    .i_minup (i_minup),
    .i_hourup(i_hourup),
    .o_msec  (o_msec),
    .o_sec   (o_sec),
    .o_min   (o_min),
    .o_hour  (o_hour),
    .o_tick  (o_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: natural tick advances the whole time as one centisecond
  // count; set pulses then add to a single field without carry.
  task automatic model_edge();
    int tot;
    if (rst) begin
      m_n = 0; m_tk = 0;
      m_ms = 0; m_s = 0; m_m = 0; m_h = 12;
    end else begin
      m_tk = ((m_n % DIV) == DIV - 1);
      m_n++;
      if (m_tk) begin
        tot = ((m_h * 60 + m_m) * 60 + m_s) * 100 + m_ms + 1;
        tot = tot % 8640000;
        m_ms = tot % 100;
        m_s  = (tot / 100) % 60;
        m_m  = (tot / 6000) % 60;
        m_h  = tot / 360000;
      end
      if (i_secup)  m_s = (m_s + 1) % 60;
      if (i_minup)  m_m = (m_m + 1) % 60;
      if (i_hourup) m_h = (m_h + 1) % 24;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("msec", o_msec, m_ms);
    chk("sec",  o_sec,  m_s);
    chk("min",  o_min,  m_m);
    chk("hour", o_hour, m_h);
    chk("tick", o_tick, m_tk);
  endtask

  function automatic int field(input int f);
    case (f)
      0:       return m_s;
      1:       return m_m;
      default: return m_h;
    endcase
  endfunction

  task automatic bump(input int f, input int target);
    bit ok;
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      if (field(f) == target) begin ok = 1; break; end
      case (f)
        0:       i_secup  = 1'b1;
        1:       i_minup  = 1'b1;
        default: i_hourup = 1'b1;
      endcase
      step();
    end
    i_secup = 1'b0; i_minup = 1'b0; i_hourup = 1'b0;
    chk("bump_reached", ok, 1);
  endtask

  task automatic wait_state(input int ms, input int ph);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2500; i++) begin
      if (m_ms == ms && (m_n % DIV) == ph) begin ok = 1; break; end
      step();
    end
    chk("wait_state", ok, 1);
  endtask

  // Cycle 1 is the first cycle with rst low.
  task automatic first_tick(output int k);
    k = -1;
    for (int i = 1; i <= 4 * DIV; i++) begin
      step();
      if (o_tick === 1'b1) begin k = i + 1; break; end
    end
  endtask

  task automatic next_tick(output int g);
    g = -1;
    for (int i = 1; i <= 4 * DIV; i++) begin
      step();
      if (o_tick === 1'b1) begin g = i; break; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int k;

  initial begin
    // Reset state and tick timing
    rst = 1'b1;
    repeat (3) step();
    chk("rst_msec", o_msec, 0);
    chk("rst_sec",  o_sec,  0);
    chk("rst_min",  o_min,  0);
    chk("rst_hour", o_hour, 12);
    chk("rst_tick", o_tick, 0);
    rst = 1'b0;
    first_tick(k);
    chk("first_tick", k, DIV + 1);
    next_tick(k);
    chk("tick_period1", k, DIV);
    next_tick(k);
    chk("tick_period2", k, DIV);

    // Preload 23:59:59.99 then full cascade rollover
    for (int i = 1; i <= 59; i++) begin
      i_hourup = (i <= 11);
      i_minup  = 1'b1;
      i_secup  = 1'b1;
      step();
    end
    i_hourup = 1'b0; i_minup = 1'b0; i_secup = 1'b0;
    wait_state(99, DIV - 1);
    chk("pre_hour", o_hour, 23);
    chk("pre_min",  o_min,  59);
    chk("pre_sec",  o_sec,  59);
    chk("pre_msec", o_msec, 99);
    step();
    chk("roll_hour", o_hour, 0);
    chk("roll_min",  o_min,  0);
    chk("roll_sec",  o_sec,  0);
    chk("roll_msec", o_msec, 0);
    chk("roll_tick", o_tick, 1);

    // Manual wraps never carry
    bump(0, 59);
    i_secup = 1'b1; step(); i_secup = 1'b0;
    chk("secwrap_sec", o_sec, 0);
    chk("secwrap_min", o_min, 0);
    bump(1, 59);
    i_minup = 1'b1; step(); i_minup = 1'b0;
    chk("minwrap_min",  o_min,  0);
    chk("minwrap_hour", o_hour, 0);
    bump(2, 23);
    i_hourup = 1'b1; step(); i_hourup = 1'b0;
    chk("hourwrap_hour", o_hour, 0);

    // Set pulse colliding with a natural carry
    do_reset();
    bump(1, 10);
    bump(0, 59);
    wait_state(99, DIV - 1);
    i_secup = 1'b1; step(); i_secup = 1'b0;
    chk("coll_sec",  o_sec,  1);
    chk("coll_min",  o_min,  11);
    chk("coll_msec", o_msec, 0);
    chk("coll_hour", o_hour, 12);

    // Simultaneous pulses, single and held
    do_reset();
    i_secup = 1'b1; i_minup = 1'b1; i_hourup = 1'b1;
    step();
    i_secup = 1'b0; i_minup = 1'b0; i_hourup = 1'b0;
    chk("sim1_hour", o_hour, 13);
    chk("sim1_min",  o_min,  1);
    chk("sim1_sec",  o_sec,  1);
    i_secup = 1'b1; i_minup = 1'b1; i_hourup = 1'b1;
    repeat (3) step();
    i_secup = 1'b0; i_minup = 1'b0; i_hourup = 1'b0;
    chk("sim3_hour", o_hour, 16);
    chk("sim3_min",  o_min,  4);
    chk("sim3_sec",  o_sec,  4);

    // Reset mid-operation at 05:30:20.45, divider count 7
    do_reset();
    for (int i = 1; i <= 30; i++) begin
      i_hourup = (i <= 17);
      i_secup  = (i <= 20);
      i_minup  = 1'b1;
      step();
    end
    i_hourup = 1'b0; i_minup = 1'b0; i_secup = 1'b0;
    wait_state(45, 7);
    chk("mid_hour", o_hour, 5);
    chk("mid_min",  o_min,  30);
    chk("mid_sec",  o_sec,  20);
    chk("mid_msec", o_msec, 45);
    do_reset();
    chk("mid_rst_hour", o_hour, 12);
    chk("mid_rst_min",  o_min,  0);
    chk("mid_rst_sec",  o_sec,  0);
    chk("mid_rst_msec", o_msec, 0);
    chk("mid_rst_tick", o_tick, 0);
    first_tick(k);
    chk("mid_first_tick", k, DIV + 1);

    // Random pulses and occasional resets against the model
    for (int i = 0; i < 1500; i++) begin
      i_secup  = ($urandom_range(0, 5) == 0);
      i_minup  = ($urandom_range(0, 5) == 0);
      i_hourup = ($urandom_range(0, 5) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      step();
    end
    i_secup = 1'b0; i_minup = 1'b0; i_hourup = 1'b0;
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
